// File: rtl/controlador_escritura_registros.sv
// rtl/controlador_escritura_registros.sv - write-side sequencer for the register bank
// Optional macro ZERO_REG_EN: requests to address 0 complete the handshake but are dropped.
module controlador_escritura_registros #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ADDR_WIDTH-1:0]         in_address,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          clear_req,
  output logic [ADDR_WIDTH-1:0]         write_address,
  output logic [DATA_WIDTH-1:0]         data_write,
  output logic                          write_enable,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_clr_idx;
  logic [ADDR_WIDTH-1:0] r_mem_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic w_full;
  logic w_accept;
  logic w_push;
  logic w_pop;

  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  assign w_accept = in_valid && !w_full;
`ifdef ZERO_REG_EN
  assign w_push   = w_accept && (in_address != '0);
`else
  assign w_push   = w_accept;
`endif
  // The clear sequence owns the write port, so the FIFO only drains outside CLEAR.
  assign w_pop    = (r_state != S_CLEAR) && (r_count != '0);

  assign in_ready      = !w_full;
  assign busy          = !((r_state == S_RUN) && (r_count == '0));
  assign fifo_count    = r_count;
  assign write_enable  = r_we;
  assign write_address = r_waddr;
  assign data_write    = r_wdata;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= in_address;
      r_mem_data[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_CLEAR;
      r_clr_idx <= '0;
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_we      <= 1'b1;
          r_waddr   <= r_clr_idx;
          r_wdata   <= '0;
          r_clr_idx <= r_clr_idx + ADDR_WIDTH'(1);
          if (r_clr_idx == '1) r_state <= S_RUN;
        end
        S_RUN, S_DRAIN: begin
          if (w_pop) begin
            r_we    <= 1'b1;
            r_waddr <= r_mem_addr[r_rd_ptr];
            r_wdata <= r_mem_data[r_rd_ptr];
          end else begin
            r_we    <= 1'b0;
          end
          if (r_state == S_RUN && clear_req) begin
            r_state <= S_DRAIN;
          end else if (r_state == S_DRAIN && r_count == '0) begin
            r_state   <= S_CLEAR;
            r_clr_idx <= '0;
          end
        end
        default: begin
          r_state   <= S_CLEAR;
          r_clr_idx <= '0;
          r_we      <= 1'b0;
        end
      endcase
    end
  end

endmodule
